uart_parity_engine: RTL and testbench
=====================================

Name: uart_parity_engine

Overview:
- Parametrised, registered parity generator for the UART TX path. It is the next generation of the combinational parity block.
- Computes the parity bit in one of two modes:
  - Parallel: whole word in one cycle.
  - Serial: bit-by-bit, in step with the shifter.
- Adds mark and space parity and a `parity_valid` handshake.
- Sits between the TX holding register or shifter and the frame FSM, which inserts `parity_out` after the last data bit.

Parameters:
- DATA_WIDTH, 8, max data bits per frame; legal range 5..9.
- CNT_W, 4, width of the serial bit counter; must satisfy 2^CNT_W > DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- parity_type  input  3  000 none, 001 odd, 010 even, 011 odd (legacy code), 100 mark, 101 space, 110/111 reserved (treated as none)
- data_len  input  CNT_W  active data bits per frame, 5..DATA_WIDTH; values outside the range are clamped to DATA_WIDTH
- serial_mode  input  1  0 parallel, 1 serial
- start  input  1  begin a computation; sampled only when busy=0
- data_in  input  DATA_WIDTH  parallel word, LSB first; bits at or above data_len are ignored
- bit_valid  input  1  serial bit strobe
- bit_in  input  1  serial data bit
- parity_en  output  1  registered; 1 when the latched type is odd, even, mark or space
- parity_out  output  1  registered parity bit; holds until the next start
- parity_valid  output  1  one-cycle pulse when parity_out updates
- busy  output  1  1 in state SER_ACC

Behaviour:
- Reset (rst=1 at a clock edge), regardless of state:
  - state=IDLE; parity_out=0, parity_valid=0, busy=0, parity_en=0.
  - Accumulator and bit counter cleared.
  - A reset mid-serial-frame aborts the frame; no parity_valid is produced.
- Configuration latch: on an accepted start, parity_type, data_len and serial_mode are latched. Later changes do not affect the frame in flight.
- Raw parity: p = XOR of the active data bits. Final bit f by type:
  - odd: ~p
  - even: p
  - mark: 1
  - space: 0
  - none/reserved: 0, and parity_en=0
- FSM states: IDLE, SER_ACC.
- IDLE, start=1, serial_mode=0 (parallel):
  - Masked XOR of data_in computed.
  - parity_out=f and parity_valid=1 on the next edge; latency 1 cycle.
  - Remains in IDLE.
- IDLE, start=1, serial_mode=1:
  - Accumulator cleared, count=0, go to SER_ACC; busy=1 from the next cycle.
  - A bit_valid in the start cycle is ignored.
- SER_ACC:
  - Each bit_valid=1 cycle: acc ^= bit_in, count += 1.
  - When the bit completing count == data_len is accepted, the next edge gives parity_out=f(acc ^ bit_in), parity_valid=1, state=IDLE, busy=0.
- Start while busy=1 is ignored (no restart).
- parity_valid is asserted exactly once per accepted start. parity_en updates on the same edge as parity_valid.
- A new start may be issued in the cycle parity_valid is high (back-to-back frames, zero bubble).
- Mark and space in serial mode still wait for data_len bits before asserting parity_valid.
- No counter wrap-around: count never exceeds data_len.

Optional Feature:
- Macro: UART_PARITY_CHECK_EN.
- Defined:
  - Adds input parity_in (1 bit) and output parity_err (1 bit, registered, reset 0).
  - On each parity_valid edge, parity_err = parity_en & (parity_in != computed f).
  - parity_in is sampled in the cycle that produces parity_valid.
  - parity_err holds until the next parity_valid or reset.
  - Lets the block be reused on the RX side.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Parallel, DATA_WIDTH=8, data_len=8, data_in=0xA5, type even → next cycle parity_out=0, parity_valid=1 for 1 cycle, parity_en=1. Same data with type odd → parity_out=1.
2. Parallel, data_len=7, data_in=0x80, type even → parity_out=0 (bit 7 masked). Repeat with data_len=8 → parity_out=1.
3. Serial, type odd, data_len=8, bits 1,0,1,1,0,0,0,0 on non-consecutive bit_valid strobes:
   - busy=1 throughout.
   - parity_valid one cycle after the 8th strobe, parity_out=0.
   - Extra bit_valid afterwards has no effect.
4. Mark/space/reserved:
   - Type 100 on any data → parity_out=1.
   - Type 101 → parity_out=0.
   - Type 111 → parity_out=0, parity_en=0.
   - Type change mid serial frame → result uses the latched type.
5. rst=1 after 4 serial bits → next cycle busy=0, parity_valid=0, parity_out=0. A following start/frame produces correct parity from a cleared accumulator. Start asserted while busy → ignored, single parity_valid.
6. With UART_PARITY_CHECK_EN: type even, data 0x0F, parity_in=1 → parity_err=1. parity_in=0 → parity_err=0. Type none, parity_in=1 → parity_err=0.

Source files
------------

// File: rtl/uart_parity_engine.sv
// uart_parity_engine: registered UART parity generator with parallel (one-shot)
// and serial (bit-by-bit) modes, none/odd/even/mark/space types and a
// parity_valid pulse.
// Optional: define UART_PARITY_CHECK_EN to add parity_in/parity_err for
// reuse as an RX parity checker.
module uart_parity_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            parity_type,
  input  logic [CNT_W-1:0]      data_len,
  input  logic                  serial_mode,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  bit_valid,
  input  logic                  bit_in,
`ifdef UART_PARITY_CHECK_EN
  input  logic                  parity_in,
  output logic                  parity_err,
`endif
  output logic                  parity_en,
  output logic                  parity_out,
  output logic                  parity_valid,
  output logic                  busy
);

  typedef enum logic [0:0] {StIdle, StSerAcc} state_e;

  state_e           state_q, state_d;
  logic [2:0]       type_q, type_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             en_q, en_d;
`ifdef UART_PARITY_CHECK_EN
  logic             err_q, err_d;
`endif

  logic [CNT_W-1:0]      len_clamped;
  logic [DATA_WIDTH-1:0] mask;
  logic                  par_raw;
  logic                  done;
  logic                  raw;
  logic [2:0]            done_type;
  logic                  final_bit;
  logic                  final_en;

  // Out-of-range lengths fall back to the full word width
  always_comb begin
    if (data_len < CNT_W'(5) || data_len > CNT_W'(DATA_WIDTH)) begin
      len_clamped = CNT_W'(DATA_WIDTH);
    end else begin
      len_clamped = data_len;
    end
    mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      mask[i] = (CNT_W'(i) < len_clamped);
    end
    par_raw = ^(data_in & mask);
  end

  // Next-state: config latch, serial accumulation, completion
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    done      = 1'b0;
    raw       = 1'b0;
    done_type = type_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          type_d = parity_type;
          len_d  = len_clamped;
          if (serial_mode) begin
            acc_d   = 1'b0;
            cnt_d   = '0;
            state_d = StSerAcc;
          end else begin
            done      = 1'b1;
            raw       = par_raw;
            done_type = parity_type;
          end
        end
      end
      StSerAcc: begin
        if (bit_valid) begin
          acc_d = acc_q ^ bit_in;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == len_q) begin
            done    = 1'b1;
            raw     = acc_q ^ bit_in;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Map raw parity to the final bit for the type in effect
  always_comb begin
    final_bit = 1'b0;
    final_en  = 1'b0;
    case (done_type)
      3'b001, 3'b011: begin final_bit = ~raw; final_en = 1'b1; end
      3'b010:         begin final_bit = raw;  final_en = 1'b1; end
      3'b100:         begin final_bit = 1'b1; final_en = 1'b1; end
      3'b101:         begin final_bit = 1'b0; final_en = 1'b1; end
      default:        begin final_bit = 1'b0; final_en = 1'b0; end
    endcase
  end

  // Result registers only move on completion; valid is a single-cycle pulse
  always_comb begin
    out_d   = out_q;
    en_d    = en_q;
    valid_d = done;
`ifdef UART_PARITY_CHECK_EN
    err_d   = err_q;
`endif
    if (done) begin
      out_d = final_bit;
      en_d  = final_en;
`ifdef UART_PARITY_CHECK_EN
      err_d = final_en & (parity_in != final_bit);
`endif
    end
  end

  // State and result registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      type_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      en_q    <= 1'b0;
`ifdef UART_PARITY_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      en_q    <= en_d;
`ifdef UART_PARITY_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign parity_out   = out_q;
  assign parity_valid = valid_q;
  assign parity_en    = en_q;
  assign busy         = (state_q == StSerAcc);
`ifdef UART_PARITY_CHECK_EN
  assign parity_err   = err_q;
`endif

endmodule

// File: tb/tb_uart_parity_engine.sv
// Scoreboard bench for uart_parity_engine: drivers push expected results,
// a negedge monitor pops and compares on every parity_valid.
module tb_uart_parity_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] parity_type;
  logic [3:0] data_len;
  logic       serial_mode;
  logic       start;
  logic [7:0] data_in;
  logic       bit_valid;
  logic       bit_in;
  logic       parity_en;
  logic       parity_out;
  logic       parity_valid;
  logic       busy;
  logic       parity_in;
`ifdef UART_PARITY_CHECK_EN
  logic       parity_err;
`endif

  typedef struct {
    logic out;
    logic en;
    logic err;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  uart_parity_engine #(.DATA_WIDTH(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .parity_type  (parity_type),
    .data_len     (data_len),
    .serial_mode  (serial_mode),
    .start        (start),
    .data_in      (data_in),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
`ifdef UART_PARITY_CHECK_EN
    .parity_in    (parity_in),
    .parity_err   (parity_err),
`endif
    .parity_en    (parity_en),
    .parity_out   (parity_out),
    .parity_valid (parity_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every parity_valid cycle must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && parity_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("parity_out", int'(parity_out), int'(e.out));
        chk("parity_en", int'(parity_en), int'(e.en));
`ifdef UART_PARITY_CHECK_EN
        chk("parity_err", int'(parity_err), int'(e.err));
`endif
      end
    end
  end

  function automatic exp_t mk(input logic eo, input logic ee, input logic pin, input int c);
    exp_t e;
    e.out = eo;
    e.en  = ee;
    e.err = ee & (pin != eo);
    e.cyc = c;
    return e;
  endfunction

  // One-cycle parallel start; result due on the next edge
  task automatic par(input logic [2:0] t, input logic [3:0] len, input logic [7:0] d,
                     input logic eo, input logic ee, input logic pin);
    parity_type = t;
    data_len    = len;
    data_in     = d;
    serial_mode = 1'b0;
    start       = 1'b1;
    parity_in   = pin;
    sb.push_back(mk(eo, ee, pin, cyc + 1));
    step();
    start = 1'b0;
  endtask

  // Serial frame with gaps between strobes; a strobe in the start cycle must be
  // ignored. chg alters parity_type mid-frame; poke issues a start while busy.
  task automatic ser(input logic [2:0] t, input logic [3:0] len, input logic [7:0] bits,
                     input int n, input logic eo, input logic ee, input logic pin,
                     input bit chg, input bit poke);
    parity_type = t;
    data_len    = len;
    serial_mode = 1'b1;
    start       = 1'b1;
    bit_valid   = 1'b1;
    bit_in      = 1'b1;
    step();
    start     = 1'b0;
    bit_valid = 1'b0;
    if (chg) parity_type = 3'b001;
    for (int i = 0; i < n; i++) begin
      chk("busy_ser", int'(busy), 1);
      if (poke && i == 2) begin
        start       = 1'b1;
        serial_mode = 1'b0;
        data_in     = 8'hFF;
      end
      step();
      start     = 1'b0;
      bit_valid = 1'b1;
      bit_in    = bits[i];
      if (i == n - 1) begin
        parity_in = pin;
        sb.push_back(mk(eo, ee, pin, cyc + 1));
      end
      step();
      bit_valid = 1'b0;
    end
    chk("busy_done", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; parity_type = '0; data_len = 4'd8; serial_mode = 1'b0; start = 1'b0;
    data_in = '0; bit_valid = 1'b0; bit_in = 1'b0; parity_in = 1'b0;
    repeat (2) step();
    chk("rst_out", int'(parity_out), 0);
    chk("rst_valid", int'(parity_valid), 0);
    chk("rst_en", int'(parity_en), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    step();

    // Parallel, back-to-back
    par(3'b010, 4'd8, 8'hA5, 1'b0, 1'b1, 1'b0);
    par(3'b001, 4'd8, 8'hA5, 1'b1, 1'b1, 1'b0);
    par(3'b010, 4'd7, 8'h80, 1'b0, 1'b1, 1'b0);
    par(3'b010, 4'd8, 8'h80, 1'b1, 1'b1, 1'b0);
    par(3'b010, 4'd3, 8'h80, 1'b1, 1'b1, 1'b0);   // clamps to 8
    par(3'b011, 4'd12, 8'h01, 1'b0, 1'b1, 1'b0);  // clamps to 8, legacy odd
    step();

    // Serial odd, 8 bits 1,0,1,1,0,0,0,0
    ser(3'b001, 4'd8, 8'b0000_1101, 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bit_valid = 1'b1; bit_in = 1'b1;
    step();
    bit_valid = 1'b0;
    step();
    chk("extra_bit_hold", int'(parity_out), 0);

    // Mark / space / reserved / none
    par(3'b100, 4'd8, 8'h00, 1'b1, 1'b1, 1'b0);
    par(3'b101, 4'd8, 8'hFF, 1'b0, 1'b1, 1'b0);
    par(3'b111, 4'd8, 8'hA5, 1'b0, 1'b0, 1'b0);
    par(3'b000, 4'd8, 8'h01, 1'b0, 1'b0, 1'b0);
    step();

    // Type change mid-frame uses latched even; mark serial waits for len bits
    ser(3'b010, 4'd5, 8'b0000_0111, 5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    ser(3'b100, 4'd5, 8'b0000_0000, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort after 4 bits
    parity_type = 3'b010; data_len = 4'd8; serial_mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in    = (i != 1);
      step();
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(parity_valid), 0);
    chk("abort_out", int'(parity_out), 0);
    chk("abort_en", int'(parity_en), 0);
    step();

    // Fresh frame from cleared accumulator, with a start poked while busy
    ser(3'b010, 4'd5, 8'b0000_0001, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();

`ifdef UART_PARITY_CHECK_EN
    par(3'b010, 4'd8, 8'h0F, 1'b0, 1'b1, 1'b1);
    par(3'b010, 4'd8, 8'h0F, 1'b0, 1'b1, 1'b0);
    par(3'b000, 4'd8, 8'h0F, 1'b0, 1'b0, 1'b1);
`endif

    repeat (4) step();
    chk("scoreboard_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
